// File: rtl/evolved_circuit_evaluator_pkg.sv
// Shared types and helpers for the evolved-circuit evaluation harness.
//   eval_state_t : harness FSM states
//   num_vec      : number of CUT input vectors for a given input width
//   sat_inc      : saturating increment at a given counter width (<= SAT_W)
package eval_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        OBSERVE,
        NEXT,
        DONE
    } eval_state_t;

    localparam int unsigned SAT_W = 32;

    function automatic int unsigned num_vec(input int unsigned w);
        return 32'd1 << w;
    endfunction

    // Increment v, clamping at the all-ones value of a w-bit counter.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input int unsigned      w);
        logic [SAT_W-1:0] lim;
        lim = {SAT_W{1'b1}} >> (SAT_W - w);
        return (v >= lim) ? lim : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/evolved_circuit_evaluator_if.sv
// Handshake and result bus between the evaluation harness and its user/CUT.
//   start       : one-cycle evaluation request
//   busy, done  : run status and one-cycle completion pulse
//   cut_in      : vector driven into the CUT
//   cut_out     : raw (asynchronous) CUT output
//   truth_table, osc_mask, toggle_max : evaluation results
// Modports: master = requester/CUT side, slave = harness.
interface evolved_circuit_evaluator_if #(
    parameter int unsigned IN_WIDTH = 2,
    parameter int unsigned CNT_W    = 16
);
    import eval_pkg::*;

    localparam int unsigned NUM_VEC = num_vec(IN_WIDTH);

    logic                start;
    logic                busy;
    logic                done;
    logic [IN_WIDTH-1:0] cut_in;
    logic                cut_out;
    logic [NUM_VEC-1:0]  truth_table;
    logic [NUM_VEC-1:0]  osc_mask;
    logic [CNT_W-1:0]    toggle_max;

    modport master (
        output start, cut_out,
        input  busy, done, cut_in, truth_table, osc_mask, toggle_max
    );

    modport slave (
        input  start, cut_out,
        output busy, done, cut_in, truth_table, osc_mask, toggle_max
    );

endinterface

// File: rtl/evolved_circuit_evaluator_sync.sv
// Two-flop synchronizer for the asynchronous CUT output.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (reset value RST_VAL)
module eval_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/evolved_circuit_evaluator.sv
// Clocked harness around an unclocked evolved netlist (CUT). Applies every
// input vector, waits SETTLE_CYCLES, then watches the synchronized output for
// OBSERVE_CYCLES, recording the sampled value, whether it toggled, and the
// worst-case toggle count.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : evolved_circuit_evaluator_if.slave (start/busy/done, CUT
//              drive and sense, result vectors)
// Build option: EVAL_GRAY_ORDER_EN applies vectors in Gray order
// (index ^ (index >> 1)); otherwise binary order. Latency is unchanged.
module evolved_circuit_evaluator
    import eval_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = 2,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned OBSERVE_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input logic                        clk,
    input logic                        rst,
    evolved_circuit_evaluator_if.slave bus
);

    localparam int unsigned NUM_VEC = num_vec(IN_WIDTH);
    localparam int unsigned PH_MAX  = (SETTLE_CYCLES > OBSERVE_CYCLES) ?
                                      SETTLE_CYCLES : OBSERVE_CYCLES;
    localparam int unsigned PH_W    = $clog2(PH_MAX);

    // Map the sequence index onto the vector actually driven into the CUT.
    function automatic logic [IN_WIDTH-1:0] vec_code(input logic [IN_WIDTH-1:0] idx);
`ifdef EVAL_GRAY_ORDER_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

    logic s_out;

    eval_sync #(.RST_VAL(1'b0)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.cut_out),
        .q   (s_out)
    );

    eval_state_t         state_q,  state_d;
    logic [IN_WIDTH-1:0] idx_q,    idx_d;
    logic [PH_W-1:0]     phase_q,  phase_d;
    logic                prev_q,   prev_d;
    logic [CNT_W-1:0]    tog_q,    tog_d;
    logic [CNT_W-1:0]    tog_upd;
    logic [NUM_VEC-1:0]  tt_q,     tt_d;
    logic [NUM_VEC-1:0]  osc_q,    osc_d;
    logic [CNT_W-1:0]    tmax_q,   tmax_d;
    logic [IN_WIDTH-1:0] cut_in_q, cut_in_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            phase_q  <= '0;
            prev_q   <= 1'b0;
            tog_q    <= '0;
            tt_q     <= '0;
            osc_q    <= '0;
            tmax_q   <= '0;
            cut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            prev_q   <= prev_d;
            tog_q    <= tog_d;
            tt_q     <= tt_d;
            osc_q    <= osc_d;
            tmax_q   <= tmax_d;
            cut_in_q <= cut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        prev_d   = prev_q;
        tog_d    = tog_q;
        tog_upd  = tog_q;
        tt_d     = tt_q;
        osc_d    = osc_q;
        tmax_d   = tmax_q;
        cut_in_d = cut_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    tt_d     = '0;
                    osc_d    = '0;
                    tmax_d   = '0;
                    idx_d    = '0;
                    phase_d  = '0;
                    cut_in_d = vec_code('0);
                    busy_d   = 1'b1;
                    state_d  = SETTLE;
                end
            end

            SETTLE: begin
                if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
                    // Baseline for toggle detection in the observe window.
                    prev_d  = s_out;
                    tog_d   = '0;
                    phase_d = '0;
                    state_d = OBSERVE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            OBSERVE: begin
                if (s_out != prev_q) begin
                    tog_upd = CNT_W'(sat_inc(SAT_W'(tog_q), CNT_W));
                end
                tog_d  = tog_upd;
                prev_d = s_out;
                if (phase_q == PH_W'(OBSERVE_CYCLES - 1)) begin
                    tt_d[cut_in_q]  = s_out;
                    osc_d[cut_in_q] = (tog_upd != '0);
                    if (tog_upd > tmax_q) begin
                        tmax_d = tog_upd;
                    end
                    phase_d = '0;
                    state_d = NEXT;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            NEXT: begin
                if (idx_q == IN_WIDTH'(NUM_VEC - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d    = idx_q + IN_WIDTH'(1);
                    cut_in_d = vec_code(idx_q + IN_WIDTH'(1));
                    state_d  = SETTLE;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cut_in      = cut_in_q;
    assign bus.truth_table = tt_q;
    assign bus.osc_mask    = osc_q;
    assign bus.toggle_max  = tmax_q;

endmodule

// File: doc/evolved_circuit_evaluator.md
Name: evolved_circuit_evaluator

Overview:
- Clocked harness stage wrapped around an evolved, unclocked LCELL netlist (circuit under test, CUT).
- Drives every input vector of the CUT in turn, waits for settling, then observes the CUT output for a fixed window.
- Reports the sampled truth table, a per-vector oscillation mask and the worst-case toggle count to the fitness logic downstream.

Parameters:
- IN_WIDTH, 2: CUT input width; 2**IN_WIDTH vectors are evaluated.
- SETTLE_CYCLES, 16: cycles per vector before observation; must be >= 3 to cover synchronizer latency.
- OBSERVE_CYCLES, 256: sampling window per vector.
- CNT_W, 16: toggle counter width; counters saturate.

Ports:
- clk  in  1  single system clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  one-cycle request to begin an evaluation.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when all results are valid.
- cut_in  out  IN_WIDTH  vector applied to the CUT.
- cut_out  in  1  CUT output; asynchronous to clk.
- truth_table  out  2**IN_WIDTH  bit v = CUT output sampled for vector v.
- osc_mask  out  2**IN_WIDTH  bit v = any toggle seen during vector v's window.
- toggle_max  out  CNT_W  maximum per-vector toggle count over the run.

Behaviour:
- Reset values: all outputs 0, including cut_in, truth_table, osc_mask and toggle_max.
  - rst during a run aborts it immediately; done is not pulsed.
- Synchronization: cut_out passes through a 2-flop synchronizer giving s_out. All logic uses s_out only.
- State machine: IDLE, SETTLE, OBSERVE, NEXT, DONE.
- IDLE:
  - start=1 clears truth_table, osc_mask and toggle_max.
  - Sets the vector index to 0 and enters SETTLE.
  - start is ignored in every other state.
- SETTLE:
  - cut_in holds the current vector for SETTLE_CYCLES cycles.
  - In the last cycle, s_out is loaded into a prev register and the toggle counter is cleared.
- OBSERVE, lasting OBSERVE_CYCLES cycles. Each cycle:
  - If s_out != prev, the counter increments, saturating at 2**CNT_W-1.
  - prev is updated to s_out.
- OBSERVE, final cycle:
  - truth_table[cut_in] <= s_out.
  - osc_mask[cut_in] <= (counter after this cycle's update != 0).
  - toggle_max <= max(toggle_max, counter after update).
- NEXT (1 cycle):
  - If the index is 2**IN_WIDTH-1, go to DONE.
  - Otherwise increment the index and go to SETTLE. cut_in changes on entry to SETTLE.
- DONE (1 cycle): done=1, busy=0, next state IDLE.
  - cut_in keeps the last vector.
  - Results hold until the next accepted start or rst.
- Latency: done is high in cycle 2**IN_WIDTH*(SETTLE_CYCLES+OBSERVE_CYCLES+1)+1 after the start cycle. The start cycle counts as cycle 0.
- start in the same cycle as done (state DONE) is ignored.

Optional Feature:
- Macro: EVAL_GRAY_ORDER_EN.
- Defined: cut_in = index ^ (index >> 1). Vectors are applied in Gray order, so exactly one CUT input changes per step (hazard exposure).
  - truth_table and osc_mask stay indexed by the actual cut_in value.
- Undefined: cut_in = index (binary order).
- Latency is identical in both builds.

Decomposition:
- Package eval_pkg:
  - state enum eval_state_t {IDLE, SETTLE, OBSERVE, NEXT, DONE}.
  - NUM_VEC = 2**IN_WIDTH, as a localparam derived in the module from the package helper.
  - Saturating-increment function.
- Sub-module eval_sync: 2-flop synchronizer, parameterised reset value 0, synchronous active-high rst.

Test Plan:
- Model CUT cut_out = ^cut_in, start pulse:
  - truth_table=4'b0110, osc_mask=0, toggle_max=0.
  - done exactly 1093 cycles after start with default parameters.
- Model CUT toggling every clk while cut_in==3, else 0; CNT_W=8:
  - osc_mask=4'b1000, toggle_max=255 (saturated), truth_table[3] equals the final sample.
- Same toggling model with CNT_W=16:
  - toggle_max=256.
- rst asserted mid-OBSERVE of vector 2:
  - Next cycle: all outputs 0, busy=0, no done pulse.
  - A new start then produces correct results.
- start repeated while busy, and start coincident with done:
  - Both ignored; exactly one done pulse per accepted start.
- EVAL_GRAY_ORDER_EN defined:
  - cut_in sequence 0,1,3,2.
  - XOR model CUT still yields truth_table=4'b0110.
